// File: rtl/vga_capture.sv
// vga_capture: samples a window of RGB pixels out of a VGA-style stream into a
// small output FIFO with a valid/ready handshake.
//
// State table
//   IDLE    | waiting for ARM; not capturing
//   WAIT_VS | armed, waiting for a VSYNC rising edge (start of frame)
//   WAIT_HS | inside a frame, waiting for the HSYNC rising edge of the next line
//   SAMPLE  | taking one pixel every CLK_DIV cycles until the line is complete
//
// Ports
//   CLK, RESET            : clock (rising edge) and asynchronous active-high reset
//   HSYNC, VSYNC, RGB     : video input, synchronous to CLK
//   ARM, CONT             : start pulse; continuous (1) or single-frame (0) mode
//   PIX_DATA/SOF/EOL      : FIFO head entry, qualified by PIX_VALID
//   PIX_VALID, PIX_READY  : output handshake; a beat moves when both are 1
//   BUSY, DONE            : capturing; one-cycle end-of-frame pulse
//   OVERFLOW, LINE_ERR,
//   FRAME_ERR             : sticky error flags, cleared by ARM
//   FRAME_CNT             : completed frames, wrapping
module vga_capture #(
  parameter int H_ACTIVE   = 705,
  parameter int V_ACTIVE   = 50,
  parameter int CLK_DIV    = 4,
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             HSYNC,
  input  logic             VSYNC,
  input  logic [PIX_W-1:0] RGB,
  input  logic             ARM,
  input  logic             CONT,
  output logic [PIX_W-1:0] PIX_DATA,
  output logic             PIX_SOF,
  output logic             PIX_EOL,
  output logic             PIX_VALID,
  input  logic             PIX_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERFLOW,
  output logic             LINE_ERR,
  output logic             FRAME_ERR,
  output logic [15:0]      FRAME_CNT
);

  localparam int PW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    WAIT_HS = 2'd2,
    SAMPLE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            hs_q, vs_q;
  logic [PW-1:0]   pix_q, pix_d;
  logic [LW-1:0]   line_q, line_d;
  logic [DW-1:0]   div_q, div_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            lerr_q, lerr_d;
  logic            ferr_q, ferr_d;

  logic            hs_rise, vs_rise;
  logic [LW-1:0]   line_inc;

  logic            push, push_sof, push_eol;
  logic            start_line, line_end, frame_end;
  logic [LW-1:0]   start_line_no, end_line_no, next_line;

  logic [PIX_W+1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             empty, full, pop, push_ok;

  assign hs_rise  = HSYNC & ~hs_q;
  assign vs_rise  = VSYNC & ~vs_q;
  assign line_inc = line_q + 1'b1;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = ~empty & PIX_READY;
  // A full FIFO still takes the sample if the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);

  always_comb begin
    state_d       = state_q;
    pix_d         = pix_q;
    line_d        = line_q;
    div_d         = div_q;
    frame_cnt_d   = frame_cnt_q;
    done_d        = 1'b0;
    ovf_d         = ovf_q;
    lerr_d        = lerr_q;
    ferr_d        = ferr_q;
    push          = 1'b0;
    push_sof      = 1'b0;
    push_eol      = 1'b0;
    start_line    = 1'b0;
    start_line_no = '0;
    line_end      = 1'b0;
    end_line_no   = line_q;
    frame_end     = 1'b0;
    next_line     = '0;

    case (state_q)
      IDLE: begin
        if (ARM) begin
          ovf_d   = 1'b0;
          lerr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (vs_rise) begin
          line_d  = '0;
          state_d = WAIT_HS;
        end
      end
      WAIT_HS: begin
        // A VSYNC edge here means the frame ended early; restart it.
        if (vs_rise) begin
          ferr_d = 1'b1;
          line_d = '0;
        end else if (hs_rise) begin
          start_line    = 1'b1;
          start_line_no = line_q;
        end
      end
      SAMPLE: begin
        if (vs_rise) begin
          ferr_d  = 1'b1;
          line_d  = '0;
          state_d = WAIT_HS;
        end else if (hs_rise) begin
          // Short line: it still counts, and the edge starts the next line.
          lerr_d = 1'b1;
          if (line_inc == LW'(V_ACTIVE)) begin
            frame_end = 1'b1;
          end else begin
            line_d        = line_inc;
            start_line    = 1'b1;
            start_line_no = line_inc;
          end
        end else if (div_q == '0) begin
          push     = 1'b1;
          push_eol = (pix_q == PW'(H_ACTIVE - 1));
          if (push_eol) begin
            line_end = 1'b1;
          end else begin
            pix_d = pix_q + 1'b1;
            div_d = DW'(CLK_DIV - 1);
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pixel 0 is taken in the same cycle as the HSYNC edge.
    if (start_line) begin
      push        = 1'b1;
      push_sof    = (start_line_no == '0);
      push_eol    = (H_ACTIVE == 1);
      pix_d       = PW'(1);
      div_d       = DW'(CLK_DIV - 1);
      end_line_no = start_line_no;
      if (H_ACTIVE == 1) line_end = 1'b1;
      else               state_d  = SAMPLE;
    end

    if (line_end) begin
      next_line = end_line_no + 1'b1;
      if (next_line == LW'(V_ACTIVE)) begin
        frame_end = 1'b1;
      end else begin
        line_d  = next_line;
        state_d = WAIT_HS;
      end
    end

    // CONT is looked at only here, so dropping it mid-frame lets the frame finish.
    if (frame_end) begin
      done_d      = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
      line_d      = '0;
      state_d     = CONT ? WAIT_VS : IDLE;
    end

    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      pix_q       <= '0;
      line_q      <= '0;
      div_q       <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      lerr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      hs_q        <= HSYNC;
      vs_q        <= VSYNC;
      pix_q       <= pix_d;
      line_q      <= line_d;
      div_q       <= div_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      lerr_q      <= lerr_d;
      ferr_q      <= ferr_d;
      wr_ptr_q    <= wr_ptr_q + (AW+1)'(push_ok);
      rd_ptr_q    <= rd_ptr_q + (AW+1)'(pop);
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= {push_sof, push_eol, RGB};
  end

  assign PIX_VALID = ~empty;
  assign {PIX_SOF, PIX_EOL, PIX_DATA} = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
  assign OVERFLOW  = ovf_q;
  assign LINE_ERR  = lerr_q;
  assign FRAME_ERR = ferr_q;
  assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_vga_capture.sv
module tb_vga_capture;
  localparam int H   = 4;
  localparam int V   = 2;
  localparam int DIV = 4;
  localparam int PW  = 8;
  localparam int FD  = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          HSYNC = 1'b0;
  logic          VSYNC = 1'b0;
  logic [PW-1:0] RGB = '0;
  logic          ARM = 1'b0;
  logic          CONT = 1'b0;
  logic          PIX_READY = 1'b1;
  logic [PW-1:0] PIX_DATA;
  logic          PIX_SOF, PIX_EOL, PIX_VALID;
  logic          BUSY, DONE, OVERFLOW, LINE_ERR, FRAME_ERR;
  logic [15:0]   FRAME_CNT;

  vga_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .CLK_DIV(DIV), .PIX_W(PW), .FIFO_DEPTH(FD)
  ) dut (
    .CLK(CLK), .RESET(RESET), .HSYNC(HSYNC), .VSYNC(VSYNC), .RGB(RGB),
    .ARM(ARM), .CONT(CONT),
    .PIX_DATA(PIX_DATA), .PIX_SOF(PIX_SOF), .PIX_EOL(PIX_EOL),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW), .LINE_ERR(LINE_ERR),
    .FRAME_ERR(FRAME_ERR), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          sof;
    logic          eol;
    logic [PW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    done_seen = 0;
  int    beats = 0;
  int    keep_left = -1;   // >=0: only this many more samples survive (stalled sink)
  bit    rand_ready = 1'b0;
  int    stall_run = 0;
  int    line_idx = 0;     // model: lines since the last VSYNC edge

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Inputs set before tick() are seen by the DUT at the coming rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_ready) begin
      // At most two stalled cycles in a row keeps the sink faster than the pixel rate.
      if (stall_run >= 2 || $urandom_range(0, 3) != 0) begin
        PIX_READY = 1'b1;
        stall_run = 0;
      end else begin
        PIX_READY = 1'b0;
        stall_run++;
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic expect_pix(logic sof, logic eol, logic [PW-1:0] data);
    beat_t b;
    if (keep_left == 0) return;
    if (keep_left > 0) keep_left--;
    b.sof  = sof;
    b.eol  = eol;
    b.data = data;
    exp_q.push_back(b);
  endtask

  // One line of len cycles starting with an HSYNC edge. Model: pixel n is the RGB
  // present n*DIV cycles after the edge, kept while n < H and n*DIV < len.
  task automatic drive_line(int len);
    for (int i = 0; i < len; i++) begin
      HSYNC = (i < 2);
      RGB   = PW'($urandom);
      if ((i % DIV) == 0 && (i / DIV) < H)
        expect_pix((line_idx == 0) && (i == 0), (i / DIV) == (H - 1), RGB);
      tick();
    end
    HSYNC = 1'b0;
    line_idx++;
  endtask

  task automatic drive_vsync();
    VSYNC = 1'b1;
    tick();
    tick();
    VSYNC = 1'b0;
    tick();
    tick();
    line_idx = 0;
  endtask

  task automatic arm(bit cont);
    CONT = cont;
    ARM  = 1'b1;
    tick();
    ARM  = 1'b0;
    tick();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every accepted beat, checks stall stability.
  initial begin
    beat_t cur, held, e;
    bit    prev_stall;
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge CLK);
      cur = {PIX_SOF, PIX_EOL, PIX_DATA};
      if (RESET) begin
        prev_stall = 1'b0;
      end else begin
        if (DONE) done_seen++;
        if (prev_stall && PIX_VALID) check("hold_stable", cur, held);
        if (PIX_VALID && PIX_READY) begin
          beats++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got beat %0h, expected none", cur);
          end else begin
            e = exp_q.pop_front();
            check("pixel_beat", cur, e);
          end
        end
        prev_stall = PIX_VALID && !PIX_READY;
        held = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, b0, len0;
    bit short_any;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", PIX_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_ovf", OVERFLOW, 0);
    check("rst_lerr", LINE_ERR, 0);
    check("rst_ferr", FRAME_ERR, 0);
    check("rst_fcnt", FRAME_CNT, 0);
    check("rst_head", {PIX_SOF, PIX_EOL, PIX_DATA}, 0);
    RESET = 1'b0;
    tick();
    check("idle_busy", BUSY, 0);

    // Nominal single frame
    arm(1'b0);
    check("nom_busy_armed", BUSY, 1);
    d0 = done_seen;
    drive_vsync();
    drive_line(16);
    drive_line(16);
    idle(4);
    check("nom_done", done_seen - d0, 1);
    check("nom_fcnt", FRAME_CNT, 1);
    check("nom_busy_end", BUSY, 0);
    check("nom_errs", {OVERFLOW, LINE_ERR, FRAME_ERR}, 0);
    drain();

    // Backpressure: sink stalled for the whole frame, only the first FD samples fit
    PIX_READY = 1'b0;
    keep_left = FD;
    arm(1'b0);
    d0 = done_seen;
    drive_vsync();
    drive_line(16);
    drive_line(16);
    idle(4);
    check("bp_ovf", OVERFLOW, 1);
    check("bp_done", done_seen - d0, 1);
    check("bp_fcnt", FRAME_CNT, 2);
    b0 = beats;
    keep_left = -1;
    PIX_READY = 1'b1;
    idle(12);
    check("bp_beats", beats - b0, FD);
    check("bp_left", exp_q.size(), 0);

    // Short first line
    arm(1'b0);
    check("sl_ovf_cleared", OVERFLOW, 0);
    d0 = done_seen;
    drive_vsync();
    drive_line(6);
    drive_line(16);
    idle(4);
    check("sl_lerr", LINE_ERR, 1);
    check("sl_ferr", FRAME_ERR, 0);
    check("sl_done", done_seen - d0, 1);
    check("sl_fcnt", FRAME_CNT, 3);
    drain();

    // Short frame: VSYNC after line 0 restarts the frame
    arm(1'b0);
    check("sf_lerr_cleared", LINE_ERR, 0);
    d0 = done_seen;
    drive_vsync();
    drive_line(16);
    drive_vsync();
    check("sf_no_done", done_seen - d0, 0);
    check("sf_ferr", FRAME_ERR, 1);
    check("sf_busy", BUSY, 1);
    check("sf_fcnt_mid", FRAME_CNT, 3);
    drive_line(16);
    drive_line(16);
    idle(4);
    check("sf_done", done_seen - d0, 1);
    check("sf_fcnt", FRAME_CNT, 4);
    drain();

    // Continuous mode with random line lengths and random sink stalls
    rand_ready = 1'b1;
    short_any = 1'b0;
    arm(1'b1);
    d0 = done_seen;
    for (int f = 0; f < 3; f++) begin
      drive_vsync();
      len0 = ($urandom_range(0, 1) != 0) ? $urandom_range(3, 12) : $urandom_range(13, 20);
      if (len0 < (H - 1) * DIV + 1) short_any = 1'b1;
      drive_line(len0);
      if (f == 2) CONT = 1'b0;
      drive_line($urandom_range(13, 20));
      idle($urandom_range(3, 6));
      check("cont_busy", BUSY, (f < 2) ? 1 : 0);
      check("cont_fcnt", FRAME_CNT, 5 + f);
    end
    check("cont_done", done_seen - d0, 3);
    check("cont_lerr", LINE_ERR, short_any);
    check("cont_ovf", OVERFLOW, 0);
    drain();
    rand_ready = 1'b0;
    PIX_READY = 1'b1;

    // Reset in the middle of a line with three samples queued
    PIX_READY = 1'b0;
    arm(1'b0);
    drive_vsync();
    for (int i = 0; i < 2 * DIV + 1; i++) begin
      HSYNC = (i < 2);
      RGB   = PW'($urandom);
      tick();
    end
    HSYNC = 1'b0;
    check("mr_pre_valid", PIX_VALID, 1);
    check("mr_pre_busy", BUSY, 1);
    #2;
    RESET = 1'b1;
    #1;
    check("mr_valid", PIX_VALID, 0);
    check("mr_busy", BUSY, 0);
    check("mr_fcnt", FRAME_CNT, 0);
    tick();
    RESET = 1'b0;
    PIX_READY = 1'b1;
    tick();
    check("mr_after_valid", PIX_VALID, 0);
    d0 = done_seen;
    arm(1'b0);
    drive_vsync();
    drive_line(16);
    drive_line(16);
    idle(4);
    check("mr_done", done_seen - d0, 1);
    check("mr_fcnt_after", FRAME_CNT, 1);
    check("mr_busy_end", BUSY, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
